// File: rtl/regfile_mp_sb_if.sv
// rtl/regfile_mp_sb_if.sv - write, read, issue and scoreboard signals of the register file
interface regfile_mp_sb_if #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 2
);
   localparam int SEL_W = $clog2(NREGS);

   logic [NWR-1:0]        wen;
   logic [NWR*SEL_W-1:0]  wsel;
   logic [NWR*DATA_W-1:0] wdat;
   logic [NRD*SEL_W-1:0]  rsel;
   logic [NRD*DATA_W-1:0] rdat;
   logic [NRD-1:0]        rbusy;
   logic                  issue_en;
   logic [SEL_W-1:0]      issue_sel;
   logic [NREGS-1:0]      busy_vec;

   modport master (
      output wen, wsel, wdat, rsel, issue_en, issue_sel,
      input  rdat, rbusy, busy_vec
   );

   modport slave (
      input  wen, wsel, wdat, rsel, issue_en, issue_sel,
      output rdat, rbusy, busy_vec
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write-to-read bypass and busy scoreboard
module regfile_mp_sb #(
   parameter int DATA_W   = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic           clk,
   input  logic           rst,
   regfile_mp_sb_if.slave bus
);
   localparam int SEL_W = $clog2(NREGS);

   logic [DATA_W-1:0] regs    [NREGS];
   logic [DATA_W-1:0] wr_data [NREGS];
   logic [NREGS-1:0]  wr_hit;
   logic [NREGS-1:0]  issue_hit;
   logic [NREGS-1:0]  busy;
   logic [NREGS-1:0]  busy_nxt;

   // Per-register write decode; scanning ports upward lets the highest port win a conflict.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         wr_hit[r]  = 1'b0;
         wr_data[r] = '0;
         for (int p = 0; p < NWR; p++) begin
            if (bus.wen[p] && (bus.wsel[p*SEL_W +: SEL_W] == SEL_W'(r))) begin
               wr_hit[r]  = 1'b1;
               wr_data[r] = bus.wdat[p*DATA_W +: DATA_W];
            end
         end
         issue_hit[r] = bus.issue_en && (bus.issue_sel == SEL_W'(r));
      end
      if (ZERO_REG != 0) begin
         wr_hit[0]    = 1'b0;
         wr_data[0]   = '0;
         issue_hit[0] = 1'b0;
      end
   end

   // Issue sets, writeback clears, and a same-cycle issue beats the clear.
   assign busy_nxt = issue_hit | (busy & ~wr_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
         busy <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (wr_hit[r]) begin
               regs[r] <= wr_data[r];
            end
         end
         busy <= busy_nxt;
      end
   end

   assign bus.busy_vec = busy;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [SEL_W-1:0]  rs;
      logic              byp;
      logic              zero;
      logic [DATA_W-1:0] val;

      assign rs   = bus.rsel[i*SEL_W +: SEL_W];
      assign byp  = (BYPASS != 0) && wr_hit[rs];
      assign zero = (ZERO_REG != 0) && (rs == '0);
      assign val  = byp ? wr_data[rs] : regs[rs];

      assign bus.rdat[i*DATA_W +: DATA_W] = zero ? '0 : val;
      assign bus.rbusy[i]                 = busy[rs] & ~byp;
   end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - bench for regfile_mp_sb: bypass, no-bypass and narrow configurations
module tb_regfile_mp_sb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_mp_sb_if #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) ifa ();
   regfile_mp_sb_if #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) ifb ();
   regfile_mp_sb_if #(.DATA_W(16), .NREGS(8),  .NRD(3), .NWR(1)) ifc ();

   regfile_mp_sb #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   regfile_mp_sb #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));
   regfile_mp_sb #(.DATA_W(16), .NREGS(8), .NRD(3), .NWR(1), .BYPASS(1), .ZERO_REG(1))
      dut_c (.clk(clk), .rst(rst), .bus(ifc));

   assign ifb.wen       = ifa.wen;
   assign ifb.wsel      = ifa.wsel;
   assign ifb.wdat      = ifa.wdat;
   assign ifb.rsel      = ifa.rsel;
   assign ifb.issue_en  = ifa.issue_en;
   assign ifb.issue_sel = ifa.issue_sel;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference state: architectural register contents and busy bits.
   logic [31:0] ma [32];
   logic [31:0] ba;
   logic [15:0] mc [8];
   logic [7:0]  bc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) ma[r] = '0;
         for (int r = 0; r < 8; r++) mc[r] = '0;
         ba = '0;
         bc = '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (ifa.wen[p] && ifa.wsel[p*5 +: 5] != 5'd0) begin
               ma[ifa.wsel[p*5 +: 5]] = ifa.wdat[p*32 +: 32];
               ba[ifa.wsel[p*5 +: 5]] = 1'b0;
            end
         end
         if (ifa.issue_en && ifa.issue_sel != 5'd0) ba[ifa.issue_sel] = 1'b1;
         if (ifc.wen[0] && ifc.wsel != 3'd0) begin
            mc[ifc.wsel] = ifc.wdat;
            bc[ifc.wsel] = 1'b0;
         end
         if (ifc.issue_en && ifc.issue_sel != 3'd0) bc[ifc.issue_sel] = 1'b1;
      end
   end

   function automatic logic [31:0] exp_rd_a(logic [4:0] s, bit byp);
      logic [31:0] v;
      if (s == 5'd0) return 32'd0;
      v = ma[s];
      if (byp)
         for (int p = 0; p < 2; p++)
            if (ifa.wen[p] && ifa.wsel[p*5 +: 5] == s) v = ifa.wdat[p*32 +: 32];
      return v;
   endfunction

   function automatic logic exp_rb_a(logic [4:0] s, bit byp);
      bit w = 0;
      for (int p = 0; p < 2; p++)
         if (ifa.wen[p] && ifa.wsel[p*5 +: 5] == s) w = 1;
      return ba[s] && !(byp && w);
   endfunction

   function automatic logic [15:0] exp_rd_c(logic [2:0] s);
      if (s == 3'd0) return 16'd0;
      if (ifc.wen[0] && ifc.wsel == s) return ifc.wdat;
      return mc[s];
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("a_rdat%0d", i), 64'(ifa.rdat[i*32 +: 32]), 64'(exp_rd_a(ifa.rsel[i*5 +: 5], 1)));
         check($sformatf("b_rdat%0d", i), 64'(ifb.rdat[i*32 +: 32]), 64'(exp_rd_a(ifa.rsel[i*5 +: 5], 0)));
         check($sformatf("a_rbusy%0d", i), 64'(ifa.rbusy[i]), 64'(exp_rb_a(ifa.rsel[i*5 +: 5], 1)));
         check($sformatf("b_rbusy%0d", i), 64'(ifb.rbusy[i]), 64'(exp_rb_a(ifa.rsel[i*5 +: 5], 0)));
      end
      check("a_busy_vec", 64'(ifa.busy_vec), 64'(ba));
      check("b_busy_vec", 64'(ifb.busy_vec), 64'(ba));
      for (int i = 0; i < 3; i++) begin
         check($sformatf("c_rdat%0d", i), 64'(ifc.rdat[i*16 +: 16]), 64'(exp_rd_c(ifc.rsel[i*3 +: 3])));
         check($sformatf("c_rbusy%0d", i), 64'(ifc.rbusy[i]),
               64'(bc[ifc.rsel[i*3 +: 3]] && !(ifc.wen[0] && ifc.wsel == ifc.rsel[i*3 +: 3])));
      end
      check("c_busy_vec", 64'(ifc.busy_vec), 64'(bc));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifa.wen      = '0;
      ifa.issue_en = 1'b0;
      ifc.wen      = '0;
      ifc.issue_en = 1'b0;
   endtask

   task automatic wr(int p, int s, logic [31:0] d);
      ifa.wen[p]          = 1'b1;
      ifa.wsel[p*5 +: 5]  = 5'(s);
      ifa.wdat[p*32 +: 32] = d;
   endtask

   initial begin
      ifa.wen = '0; ifa.wsel = '0; ifa.wdat = '0; ifa.rsel = '0;
      ifa.issue_en = 1'b0; ifa.issue_sel = '0;
      ifc.wen = '0; ifc.wsel = '0; ifc.wdat = '0; ifc.rsel = '0;
      ifc.issue_en = 1'b0; ifc.issue_sel = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Fill regs 1..31 and mark each busy in the same cycle.
      for (int r = 1; r < 32; r++) begin
         idle();
         wr(0, r, 32'h1000_0000 + 32'(r) * 32'h11);
         ifa.issue_en  = 1'b1;
         ifa.issue_sel = 5'(r);
         step();
      end
      idle();
      ifa.rsel = {5'd31, 5'd5};
      #2;
      check("lit_reg5", 64'(ifb.rdat[31:0]), 64'h1000_0055);
      check("lit_reg31", 64'(ifb.rdat[63:32]), 64'h1000_020F);
      check("lit_busy_full", 64'(ifa.busy_vec), 64'hFFFF_FFFE);

      // Asynchronous reset mid-cycle with a write in flight.
      step();
      #1 rst = 1'b1;
      wr(0, 5, 32'h77);
      #1;
      check("lit_rst_rdat_b", 64'(ifb.rdat), 64'h0);
      check("lit_rst_bypass_a", 64'(ifa.rdat[31:0]), 64'h77);
      check("lit_rst_busy", 64'(ifa.busy_vec), 64'h0);
      check("lit_rst_rbusy", 64'(ifa.rbusy), 64'h0);
      step();
      rst = 1'b0;
      idle();
      #2;
      check("lit_reg5_after_rst", 64'(ifa.rdat[31:0]), 64'h0);

      // Write visible next cycle without bypass, same cycle with bypass.
      step();
      wr(0, 7, 32'hDEAD_BEEF);
      ifa.rsel = {5'd7, 5'd7};
      #2;
      check("lit_nobyp_old", 64'(ifb.rdat[31:0]), 64'h0);
      check("lit_byp_new", 64'(ifa.rdat[31:0]), 64'hDEAD_BEEF);
      step();
      idle();
      #2;
      check("lit_nobyp_next", 64'(ifb.rdat), 64'hDEAD_BEEF_DEAD_BEEF);

      // Bypass, then a two-port conflict on the same register.
      step();
      wr(0, 9, 32'h1234_5678);
      ifa.rsel = {5'd9, 5'd7};
      #2;
      check("lit_byp_r9", 64'(ifa.rdat[63:32]), 64'h1234_5678);
      step();
      idle();
      wr(0, 9, 32'h1);
      wr(1, 9, 32'h2);
      ifa.rsel = {5'd9, 5'd9};
      #2;
      check("lit_conflict_byp", 64'(ifa.rdat[31:0]), 64'h2);
      step();
      idle();
      #2;
      check("lit_conflict_store", 64'(ifb.rdat[31:0]), 64'h2);

      // Register 0 ignores writes and issues.
      step();
      wr(0, 0, 32'hFFFF_FFFF);
      ifa.issue_en  = 1'b1;
      ifa.issue_sel = 5'd0;
      ifa.rsel = {5'd0, 5'd0};
      #2;
      check("lit_zero_byp", 64'(ifa.rdat[31:0]), 64'h0);
      step();
      idle();
      #2;
      check("lit_zero_busy", 64'(ifa.busy_vec[0]), 64'h0);
      check("lit_zero_store", 64'(ifb.rdat[31:0]), 64'h0);

      // Scoreboard on register 12.
      step();
      ifa.issue_en  = 1'b1;
      ifa.issue_sel = 5'd12;
      ifa.rsel = {5'd0, 5'd12};
      #2;
      check("lit_issue_not_yet", 64'(ifa.rbusy[0]), 64'h0);
      step();
      idle();
      #2;
      check("lit_busy12", 64'(ifa.busy_vec[12]), 64'h1);
      check("lit_rbusy12", 64'(ifa.rbusy[0]), 64'h1);
      step();
      wr(1, 12, 32'hABCD_0012);
      #2;
      check("lit_wb_rbusy_byp", 64'(ifa.rbusy[0]), 64'h0);
      check("lit_wb_rbusy_nobyp", 64'(ifb.rbusy[0]), 64'h1);
      step();
      idle();
      #2;
      check("lit_busy12_clear", 64'(ifa.busy_vec[12]), 64'h0);
      step();
      wr(0, 12, 32'h5555);
      ifa.issue_en  = 1'b1;
      ifa.issue_sel = 5'd12;
      step();
      idle();
      #2;
      check("lit_issue_wins", 64'(ifa.busy_vec[12]), 64'h1);
      check("lit_issue_wr_data", 64'(ifb.rdat[31:0]), 64'h5555);

      // Mixed traffic checked cycle by cycle against the model.
      for (int k = 0; k < 16; k++) begin
         ifa.wen       = 2'(k);
         ifa.wsel      = {5'(k * 7), 5'(k * 3)};
         ifa.wdat      = {~(32'(k) * 32'h0101_0101), 32'(k) * 32'h0101_0101};
         ifa.rsel      = {5'(k * 5), 5'(k * 3)};
         ifa.issue_en  = 1'(k);
         ifa.issue_sel = 5'(k * 11);
         step();
      end
      idle();

      // Narrow configuration: write every register, then read with rotated selects.
      for (int r = 0; r < 8; r++) begin
         ifc.wen  = 1'b1;
         ifc.wsel = 3'(r);
         ifc.wdat = 16'hA000 + 16'(r) * 16'h0101;
         for (int i = 0; i < 3; i++) ifc.rsel[i*3 +: 3] = 3'(r);
         step();
      end
      idle();
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 3; i++) ifc.rsel[i*3 +: 3] = 3'(r + i);
         step();
      end
      ifc.rsel = {3'd7, 3'd3, 3'd0};
      #2;
      check("lit_c_read", 64'(ifc.rdat), 64'h0000_A707_A303_0000);
      step();
      ifc.issue_en  = 1'b1;
      ifc.issue_sel = 3'd5;
      step();
      idle();
      #2;
      check("lit_c_busy5", 64'(ifc.busy_vec), 64'h20);
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
